// File: rtl/mem_pkg.sv
// Shared definitions for the banked program-memory loader.
// Contents:
//   DEF_ADDR_W    - default log2 of memory depth in words
//   DEF_NUM_BANKS - default number of byte lanes per word
//   state_t       - loader FSM state encoding (LOAD / RUN / ERR)
package mem_pkg;

  localparam int DEF_ADDR_W    = 8;
  localparam int DEF_NUM_BANKS = 4;

  typedef enum logic [1:0] {
    ST_LOAD = 2'd0,
    ST_RUN  = 2'd1,
    ST_ERR  = 2'd2
  } state_t;

endpackage

// File: rtl/byte_bank.sv
// One byte lane of the program memory: a byte-wide array with a single
// synchronous write port and an asynchronous read port.
// Ports:
//   clk   - rising-edge clock
//   we    - write enable for this lane
//   waddr - word index written at the clock edge
//   wdata - byte written
//   raddr - word index read combinationally
//   rdata - byte read
// Contents are never reset, so a reset mid-load keeps already written words.
module byte_bank
  import mem_pkg::*;
#(
  parameter int ADDR_W = DEF_ADDR_W
) (
  input  logic              clk,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [7:0]        wdata,
  input  logic [ADDR_W-1:0] raddr,
  output logic [7:0]        rdata
);

  localparam int DEPTH = 1 << ADDR_W;

  logic [7:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/banked_mem_loader.sv
// Program-memory loader: streams an image into NUM_BANKS byte-wide banks
// through a valid/ready port, then hands the memory to a CPU port that can
// read in any state and write byte lanes once the image is loaded.
// Ports:
//   clk, rst           - clock; asynchronous active-high reset
//   ld_valid/ld_ready  - load handshake (ready only while loading)
//   ld_data, ld_last   - load word and end-of-image marker
//   run                - image loaded, CPU may execute
//   load_err           - sticky: a beat arrived with the memory already full
//   words_loaded       - number of beats accepted and stored
//   cpu_addr           - byte address; upper bits beyond the depth wrap
//   cpu_rdata          - combinational read word
//   cpu_we, cpu_be,
//   cpu_wdata          - byte-lane write port, active in RUN only
//   misalign           - misaligned-write flag
// Optional feature (macro BANKED_MEM_MISALIGN_CHK_EN): when defined, RUN
// writes with nonzero lane-offset address bits are dropped and misalign
// pulses for that cycle; when undefined misalign is 0 and the offset bits
// are ignored on writes.
module banked_mem_loader
  import mem_pkg::*;
#(
  parameter  int ADDR_W    = DEF_ADDR_W,
  parameter  int NUM_BANKS = DEF_NUM_BANKS,
  localparam int DATA_W    = 8 * NUM_BANKS
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              ld_valid,
  output logic              ld_ready,
  input  logic [DATA_W-1:0] ld_data,
  input  logic              ld_last,
  output logic              run,
  output logic              load_err,
  output logic [ADDR_W:0]   words_loaded,
  input  logic [31:0]       cpu_addr,
  output logic [DATA_W-1:0] cpu_rdata,
  input  logic              cpu_we,
  input  logic [NUM_BANKS-1:0] cpu_be,
  input  logic [DATA_W-1:0] cpu_wdata,
  output logic              misalign
);

  localparam int LANE_W = $clog2(NUM_BANKS);
  // ptr value meaning "every word has been written"
  localparam logic [ADDR_W:0] PTR_FULL  = {1'b1, {ADDR_W{1'b0}}};
  localparam logic [ADDR_W:0] PTR_ONE   = {{ADDR_W{1'b0}}, 1'b1};
  localparam logic [31:0]     LANE_MASK = 32'(NUM_BANKS - 1);

  state_t state_reg, state_next;
  logic [ADDR_W:0] ptr_reg, ptr_next;

  logic              load_we;
  logic              cpu_wr_ok;
  logic              misalign_hit;
  logic [ADDR_W-1:0] cpu_word;
  logic [ADDR_W-1:0] bank_waddr;
  logic              unused_addr;

  // Word index of the CPU byte address; bits above it are ignored (wrap).
  assign cpu_word    = cpu_addr[LANE_W +: ADDR_W];
  assign unused_addr = ^cpu_addr;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg <= ST_LOAD;
      ptr_reg   <= '0;
    end else begin
      state_reg <= state_next;
      ptr_reg   <= ptr_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    ptr_next   = ptr_reg;
    load_we    = 1'b0;
    ld_ready   = 1'b0;
    run        = 1'b0;
    load_err   = 1'b0;
    case (state_reg)
      ST_LOAD: begin
        ld_ready = 1'b1;
        if (ld_valid) begin
          // A beat beyond the last word is dropped rather than wrapped, so
          // the overflow check wins over ld_last.
          if (ptr_reg == PTR_FULL) begin
            state_next = ST_ERR;
          end else begin
            load_we  = 1'b1;
            ptr_next = ptr_reg + PTR_ONE;
            if (ld_last) begin
              state_next = ST_RUN;
            end
          end
        end
      end
      ST_RUN: begin
        run = 1'b1;
      end
      ST_ERR: begin
        load_err = 1'b1;
      end
      default: begin
        state_next = ST_LOAD;
      end
    endcase
  end

  assign words_loaded = ptr_reg;

`ifdef BANKED_MEM_MISALIGN_CHK_EN
  assign misalign_hit = (state_reg == ST_RUN) && cpu_we &&
                        ((cpu_addr & LANE_MASK) != 32'd0);
`else
  assign misalign_hit = 1'b0;
`endif

  assign misalign  = misalign_hit;
  assign cpu_wr_ok = (state_reg == ST_RUN) && cpu_we && !misalign_hit;

  // Loader and CPU never write in the same state, so one write port per
  // bank is shared between them.
  assign bank_waddr = load_we ? ptr_reg[ADDR_W-1:0] : cpu_word;

  generate
    for (genvar gi = 0; gi < NUM_BANKS; gi++) begin : g_bank
      logic       bank_we;
      logic [7:0] bank_wdata;

      assign bank_we    = load_we || (cpu_wr_ok && cpu_be[gi]);
      assign bank_wdata = load_we ? ld_data[8*gi +: 8] : cpu_wdata[8*gi +: 8];

      byte_bank #(
        .ADDR_W (ADDR_W)
      ) u_bank (
        .clk   (clk),
        .we    (bank_we),
        .waddr (bank_waddr),
        .wdata (bank_wdata),
        .raddr (cpu_word),
        .rdata (cpu_rdata[8*gi +: 8])
      );
    end
  endgenerate

endmodule

// File: tb/tb_banked_mem_loader.sv
// Self-checking bench for banked_mem_loader: a default-size instance
// (ADDR_W=8, 4 lanes) for load/run/CPU traffic and a small instance
// (ADDR_W=2) for the full-memory boundary and overflow cases.
module tb_banked_mem_loader;
  import mem_pkg::*;

  localparam int AW  = 8;
  localparam int SAW = 2;

`ifdef BANKED_MEM_MISALIGN_CHK_EN
  localparam bit CHK_EN = 1'b1;
`else
  localparam bit CHK_EN = 1'b0;
`endif

  logic clk = 1'b0;
  always #5 clk = ~clk;

  // main instance
  logic        rst, ld_valid, ld_ready, ld_last, run, load_err, cpu_we, misalign;
  logic [31:0] ld_data, cpu_addr, cpu_rdata, cpu_wdata;
  logic [3:0]  cpu_be;
  logic [AW:0] words_loaded;

  // small instance
  logic         s_rst, s_ld_valid, s_ld_ready, s_ld_last, s_run, s_load_err, s_cpu_we, s_misalign;
  logic [31:0]  s_ld_data, s_cpu_addr, s_cpu_rdata, s_cpu_wdata;
  logic [3:0]   s_cpu_be;
  logic [SAW:0] s_words_loaded;

  banked_mem_loader #(.ADDR_W(AW), .NUM_BANKS(4)) dut (
    .clk(clk), .rst(rst), .ld_valid(ld_valid), .ld_ready(ld_ready),
    .ld_data(ld_data), .ld_last(ld_last), .run(run), .load_err(load_err),
    .words_loaded(words_loaded), .cpu_addr(cpu_addr), .cpu_rdata(cpu_rdata),
    .cpu_we(cpu_we), .cpu_be(cpu_be), .cpu_wdata(cpu_wdata), .misalign(misalign)
  );

  banked_mem_loader #(.ADDR_W(SAW), .NUM_BANKS(4)) dut_s (
    .clk(clk), .rst(s_rst), .ld_valid(s_ld_valid), .ld_ready(s_ld_ready),
    .ld_data(s_ld_data), .ld_last(s_ld_last), .run(s_run), .load_err(s_load_err),
    .words_loaded(s_words_loaded), .cpu_addr(s_cpu_addr), .cpu_rdata(s_cpu_rdata),
    .cpu_we(s_cpu_we), .cpu_be(s_cpu_be), .cpu_wdata(s_cpu_wdata), .misalign(s_misalign)
  );

  int total = 0;
  int bad   = 0;

  // Reference memory for the main instance: word-level contents plus a flag
  // saying whether the word holds a value the bench has put there.
  logic [31:0] model_mem   [256];
  bit          model_known [256];

  typedef struct {
    logic [31:0] data;
    logic        last;
    int          gap_before;
    logic [AW:0] exp_words;
    logic        exp_run;
  } ld_vec_t;

  ld_vec_t prog [6];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic beat(input logic [31:0] d, input logic last);
    ld_valid = 1'b1;
    ld_data  = d;
    ld_last  = last;
    tick();
    ld_valid = 1'b0;
    ld_last  = 1'b0;
    $display("load beat data=%h last=%0b -> words=%0d run=%0b", d, last, words_loaded, run);
  endtask

  task automatic read_chk(input string name, input logic [31:0] addr, input logic [31:0] exp);
    cpu_addr = addr;
    #1;
    chk(name, cpu_rdata, exp);
  endtask

  // One CPU access on the main instance, checked against the word model:
  // no bypass before the edge, merged lanes after it.
  task automatic cpu_op(input logic [31:0] addr, input logic we, input logic [3:0] be,
                        input logic [31:0] wd);
    int          w;
    logic [31:0] old_w, new_w;
    logic        mis;
    w     = int'((addr >> 2) & 32'hFF);
    old_w = model_mem[w];
    mis   = CHK_EN && we && (addr[1:0] != 2'b00);
    new_w = old_w;
    if (we && !mis) begin
      for (int k = 0; k < 4; k++) begin
        if (be[k]) new_w[8*k +: 8] = wd[8*k +: 8];
      end
    end
    cpu_addr  = addr;
    cpu_we    = we;
    cpu_be    = be;
    cpu_wdata = wd;
    #1;
    chk("misalign_pulse", {31'd0, misalign}, {31'd0, mis});
    if (model_known[w]) chk("no_bypass", cpu_rdata, old_w);
    tick();
    cpu_we = 1'b0;
    chk("write_result", cpu_rdata, new_w);
    chk("misalign_clear", {31'd0, misalign}, 32'd0);
    model_mem[w] = new_w;
    if (we && !mis && be == 4'hF) model_known[w] = 1'b1;
    $display("cpu op addr=%h we=%0b be=%b wdata=%h -> rdata=%h", addr, we, be, wd, cpu_rdata);
  endtask

  task automatic s_beat(input logic [31:0] d, input logic last);
    s_ld_valid = 1'b1;
    s_ld_data  = d;
    s_ld_last  = last;
    tick();
    s_ld_valid = 1'b0;
    s_ld_last  = 1'b0;
    $display("small beat data=%h last=%0b -> words=%0d run=%0b err=%0b",
             d, last, s_words_loaded, s_run, s_load_err);
  endtask

  initial begin
    logic [31:0] pre [3];
    logic [31:0] a;
    int          wi;

    prog[0] = '{32'h00A00093, 1'b0, 0, 9'd1, 1'b0};
    prog[1] = '{32'h01400113, 1'b0, 0, 9'd2, 1'b0};
    prog[2] = '{32'h002081B3, 1'b0, 2, 9'd3, 1'b0};
    prog[3] = '{32'h00302023, 1'b0, 0, 9'd4, 1'b0};
    prog[4] = '{32'h00002203, 1'b0, 1, 9'd5, 1'b0};
    prog[5] = '{32'h401202B3, 1'b1, 0, 9'd6, 1'b1};
    pre[0] = 32'h11223344;
    pre[1] = 32'h55667788;
    pre[2] = 32'h99AABBCC;
    for (int i = 0; i < 256; i++) begin
      model_mem[i]   = 32'd0;
      model_known[i] = 1'b0;
    end

    rst = 1'b1; ld_valid = 1'b0; ld_last = 1'b0; ld_data = '0;
    cpu_addr = '0; cpu_we = 1'b0; cpu_be = '0; cpu_wdata = '0;
    s_rst = 1'b1; s_ld_valid = 1'b0; s_ld_last = 1'b0; s_ld_data = '0;
    s_cpu_addr = '0; s_cpu_we = 1'b0; s_cpu_be = '0; s_cpu_wdata = '0;
    #2;
    chk("reset_ld_ready", {31'd0, ld_ready}, 32'd1);
    chk("reset_run", {31'd0, run}, 32'd0);
    chk("reset_load_err", {31'd0, load_err}, 32'd0);
    chk("reset_words", 32'(words_loaded), 32'd0);
    chk("reset_misalign", {31'd0, misalign}, 32'd0);
    tick();
    tick();
    rst = 1'b0;

    // Partial load, ignored CPU write in LOAD, then reset mid-load.
    for (int i = 0; i < 3; i++) begin
      beat(pre[i], 1'b0);
      chk("pre_words", 32'(words_loaded), 32'(i + 1));
    end
    cpu_addr = 32'd4; cpu_be = 4'hF; cpu_wdata = 32'hDEADBEEF; cpu_we = 1'b1;
    tick();
    cpu_we = 1'b0;
    chk("load_ignores_cpu_we", 32'(words_loaded), 32'd3);
    rst = 1'b1;
    #1;
    chk("async_reset_words", 32'(words_loaded), 32'd0);
    chk("async_reset_ready", {31'd0, ld_ready}, 32'd1);
    tick();
    rst = 1'b0;
    for (int i = 0; i < 3; i++) read_chk("kept_after_reset", 32'(i * 4), pre[i]);

    // Program image from the table, with idle gaps on some beats.
    for (int i = 0; i < 6; i++) begin
      for (int g = 0; g < prog[i].gap_before; g++) begin
        ld_data = $urandom;
        tick();
        chk("gap_holds_ptr", 32'(words_loaded), 32'(i));
      end
      chk("run_before_beat", {31'd0, run}, 32'd0);
      beat(prog[i].data, prog[i].last);
      chk("beat_words", 32'(words_loaded), 32'(prog[i].exp_words));
      chk("beat_run", {31'd0, run}, {31'd0, prog[i].exp_run});
      model_mem[i]   = prog[i].data;
      model_known[i] = 1'b1;
    end
    chk("run_ld_ready", {31'd0, ld_ready}, 32'd0);
    chk("run_load_err", {31'd0, load_err}, 32'd0);
    read_chk("read_addr8", 32'd8, 32'h002081B3);
    for (int i = 0; i < 6; i++) read_chk("prog_word", 32'(i * 4), prog[i].data);

    // Beats offered in RUN are not accepted.
    beat(32'hFFFFFFFF, 1'b1);
    chk("run_ignores_beat", 32'(words_loaded), 32'd6);

    // Byte-lane write to word 0.
    cpu_op(32'd0, 1'b1, 4'b0010, 32'h0000AB00);
    read_chk("lane1_write", 32'd0, 32'h00A0AB93);

    // Write at byte address 2 (lane offset nonzero).
    cpu_op(32'd2, 1'b1, 4'hF, 32'hCAFEF00D);

    // Fill words 6..15 so random reads have defined contents.
    for (int w = 6; w < 16; w++) cpu_op(32'(w * 4), 1'b1, 4'hF, $urandom);

    // Random traffic over words 0..15 with random upper address bits (wrap).
    for (int n = 0; n < 200; n++) begin
      wi = int'($urandom_range(0, 15));
      a  = ($urandom & 32'hFFFFFC00) | 32'(wi * 4);
      if ($urandom_range(0, 3) == 0) a = a | 32'($urandom_range(1, 3));
      cpu_op(a, $urandom_range(0, 1) == 1, 4'($urandom_range(0, 15)), $urandom);
    end

    // Small instance: last beat exactly at the final word.
    tick();
    s_rst = 1'b0;
    for (int i = 0; i < 4; i++) s_beat(32'hA0000000 | 32'(i), i == 3);
    chk("s_full_run", {31'd0, s_run}, 32'd1);
    chk("s_full_no_err", {31'd0, s_load_err}, 32'd0);
    chk("s_full_words", 32'(s_words_loaded), 32'd4);
    s_cpu_addr = 32'd16;
    #1;
    chk("s_addr_wrap", s_cpu_rdata, 32'hA0000000);

    // Small instance: overflow into ERR.
    s_rst = 1'b1;
    #1;
    chk("s_reset_run", {31'd0, s_run}, 32'd0);
    tick();
    s_rst = 1'b0;
    for (int i = 0; i < 5; i++) begin
      s_beat(32'h11111111 * 32'(i + 1), 1'b0);
      chk("s_ovf_words", 32'(s_words_loaded), (i < 4) ? 32'(i + 1) : 32'd4);
    end
    chk("s_err_flag", {31'd0, s_load_err}, 32'd1);
    chk("s_err_run", {31'd0, s_run}, 32'd0);
    chk("s_err_ready", {31'd0, s_ld_ready}, 32'd0);
    s_cpu_addr = 32'd0;
    #1;
    chk("s_dropped_beat", s_cpu_rdata, 32'h11111111);
    s_cpu_we = 1'b1; s_cpu_be = 4'hF; s_cpu_wdata = 32'h0BADF00D;
    tick();
    s_cpu_we = 1'b0;
    chk("s_err_ignores_cpu_we", s_cpu_rdata, 32'h11111111);
    s_beat(32'h77777777, 1'b1);
    chk("s_err_sticky", {31'd0, s_load_err}, 32'd1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/banked_mem_loader.md
BANKED_MEM_LOADER -- requirements
Module: banked_mem_loader

Interface
REQ-001 SHALL have parameter: ADDR_W, default 8, log2 of memory depth in words (DEPTH = 2**ADDR_W).
REQ-002 SHALL have parameter: NUM_BANKS, default 4, byte lanes per word; DATA_W = 8*NUM_BANKS; NUM_BANKS is a power of two.
REQ-003 SHALL have port: clk  input  1  single clock, rising-edge.
REQ-004 SHALL have port: rst  input  1  reset, asynchronous, active-high.
REQ-005 SHALL have port: ld_valid  input  1  load beat valid.
REQ-006 SHALL have port: ld_ready  output  1  load beat accepted when ld_valid & ld_ready.
REQ-007 SHALL have port: ld_data  input  DATA_W  load word.
REQ-008 SHALL have port: ld_last  input  1  final beat of the program image.
REQ-009 SHALL have port: run  output  1  image loaded; CPU may execute.
REQ-010 SHALL have port: load_err  output  1  sticky overflow flag.
REQ-011 SHALL have port: words_loaded  output  ADDR_W+1  count of accepted, stored beats.
REQ-012 SHALL have port: cpu_addr  input  32  byte address.
REQ-013 SHALL have port: cpu_rdata  output  DATA_W  read word.
REQ-014 SHALL have port: cpu_we  input  1  write strobe.
REQ-015 SHALL have port: cpu_be  input  NUM_BANKS  byte-lane enables.
REQ-016 SHALL have port: cpu_wdata  input  DATA_W  write word.
REQ-017 SHALL have port: misalign  output  1  misaligned write flag (see Configuration).

Function
REQ-018 SHALL store data in NUM_BANKS byte-wide arrays bank0..bankN-1 of DEPTH entries; lane k holds bits [8k+7:8k].
REQ-019 SHALL use a 3-state FSM: LOAD, RUN, ERR.
REQ-020 SHALL hold ld_ready=1 in LOAD only, and ld_ready=0 in RUN and ERR.
REQ-021 SHALL, in LOAD, write an accepted beat to word index ptr on all lanes and increment ptr and words_loaded in the same edge.
REQ-022 SHALL not advance ptr on cycles with ld_valid=0.
REQ-023 SHALL move LOAD->RUN on an accepted beat with ld_last=1; run=1 from the following cycle.
REQ-024 SHALL, on a beat accepted when ptr==DEPTH, drop the data, set load_err, and move to ERR; ERR is exit-only by reset.
REQ-025 SHALL treat a last beat at ptr==DEPTH-1 as a normal transition to RUN, with no error.
REQ-026 SHALL return cpu_rdata combinationally from word index cpu_addr[log2(NUM_BANKS)+ADDR_W-1 : log2(NUM_BANKS)] in every state; upper address bits are ignored, so addresses wrap.
REQ-027 SHALL, in RUN only, write lane k at the rising edge when cpu_we & cpu_be[k]; cpu_we is ignored in LOAD and ERR.
REQ-028 SHALL give a read of the same word a write-first view only after the edge; there is no bypass.

Reset
REQ-029 SHALL, on rst, immediately force state=LOAD, ptr=0, words_loaded=0, run=0, load_err=0, misalign=0 and ld_ready=1 (asynchronous).
REQ-030 SHALL not clear memory contents on reset; a reset mid-load leaves already written words intact.

Configuration
REQ-031 SHALL, with BANKED_MEM_MISALIGN_CHK_EN defined, suppress a RUN write whose cpu_addr low log2(NUM_BANKS) bits are nonzero, and pulse misalign=1 for that cycle.
REQ-032 SHALL, without BANKED_MEM_MISALIGN_CHK_EN, tie misalign to 0 and ignore the low address bits on writes.

Structure
REQ-033 SHALL place FSM state encodings (LOAD/RUN/ERR) and the default ADDR_W/NUM_BANKS constants in shared package mem_pkg.
REQ-034 SHALL implement one sub-module, byte_bank (single byte-wide array with write enable and async read), instantiated NUM_BANKS times.

Verification
REQ-035 SHALL verify: load 00A00093, 01400113, 002081B3, 00302023, 00002203, 401202B3 with ld_last on beat 6 -> run=1 the next cycle, words_loaded=6, cpu_addr=8 reads 002081B3.
REQ-036 SHALL verify: in RUN, cpu_we=1, cpu_be=0010, cpu_wdata=0000AB00, addr 0 -> word 0 reads 00A0AB93.
REQ-037 SHALL verify: ADDR_W=2, 5 beats with no ld_last -> load_err=1, state ERR, run=0, ld_ready=0, words_loaded=4.
REQ-038 SHALL verify: rst asserted after 3 beats -> words_loaded=0, ld_ready=1 immediately, and words 0-2 still readable.
REQ-039 SHALL verify: ld_valid low for 2 cycles between beats -> ptr holds, and the next word lands at the correct index.
REQ-040 SHALL verify, with BANKED_MEM_MISALIGN_CHK_EN: write at addr 2 -> misalign=1 for one cycle and memory unchanged.
